// File: rtl/conv_share_arb.sv
// Round-robin arbiter sharing one convolution engine between NREQ AXI-Stream requesters.
// Optional per-requester job counters are compiled in with `define ARB_STATS_EN.
module conv_share_arb #(
    parameter int unsigned INW    = 18,
    parameter int unsigned R      = 9,
    parameter int unsigned C      = 8,
    parameter int unsigned MAXK   = 5,
    parameter int unsigned NREQ   = 2,
    parameter int unsigned OUTW   = $clog2(64'(MAXK) * 64'(MAXK) * (64'd1 << (2 * INW - 2))
                                           + (64'd1 << (INW - 1))) + 1,
    parameter int unsigned K_BITS = $clog2(MAXK + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NREQ*INW-1:0]        REQ_TDATA,
    input  logic [NREQ*(K_BITS+1)-1:0] REQ_TUSER,
    input  logic [NREQ-1:0]            REQ_TVALID,
    input  logic [NREQ-1:0]            REQ_TLAST,
    output logic [NREQ-1:0]            REQ_TREADY,
    output logic [OUTW-1:0]            RSP_TDATA,
    output logic [NREQ-1:0]            RSP_TVALID,
    input  logic [NREQ-1:0]            RSP_TREADY,
    output logic [INW-1:0]             ENG_IN_TDATA,
    output logic [K_BITS:0]            ENG_IN_TUSER,
    output logic                       ENG_IN_TVALID,
    input  logic                       ENG_IN_TREADY,
    input  logic [OUTW-1:0]            ENG_OUT_TDATA,
    input  logic                       ENG_OUT_TVALID,
    output logic                       ENG_OUT_TREADY,
`ifdef ARB_STATS_EN
    output logic [NREQ*16-1:0]         job_done_cnt,
`endif
    output logic                       busy,
    output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] grant
);

    localparam int unsigned GW    = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CNT_W = $clog2(R * C + 1);
    localparam int unsigned TU_W  = K_BITS + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN} state_e;

    state_e              state_q, state_d;
    logic [GW-1:0]       rr_q, rr_d;
    logic [GW-1:0]       grant_q, grant_d;
    logic [K_BITS-1:0]   k_q, k_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [INW-1:0]      sel_data;
    logic [TU_W-1:0]     sel_user;
    logic                sel_valid;
    logic                sel_last;
    logic                sel_rsp_ready;
    logic                in_hs;
    logic                out_hs;
    logic                job_done;
    logic                pick_found;
    logic [GW-1:0]       pick_idx;
    logic [GW-1:0]       next_ptr;
    logic [K_BITS-1:0]   k_eff;

    // Number of valid output positions for a kernel of size k
    function automatic logic [CNT_W-1:0] calc_cnt(input logic [K_BITS-1:0] k);
        int rows;
        int cols;
        rows = int'(R) + 1 - int'(k);
        cols = int'(C) + 1 - int'(k);
        return CNT_W'(rows * cols);
    endfunction

    assign sel_data      = REQ_TDATA[int'(grant_q) * INW +: INW];
    assign sel_user      = REQ_TUSER[int'(grant_q) * TU_W +: TU_W];
    assign sel_valid     = REQ_TVALID[grant_q];
    assign sel_last      = REQ_TLAST[grant_q];
    assign sel_rsp_ready = RSP_TREADY[grant_q];

    assign in_hs    = (state_q == ST_LOAD) && sel_valid && ENG_IN_TREADY;
    assign out_hs   = (state_q == ST_RUN) && ENG_OUT_TVALID && sel_rsp_ready;
    assign job_done = out_hs && (cnt_q == CNT_W'(1));
    assign k_eff    = sel_user[0] ? sel_user[K_BITS:1] : k_q;
    assign next_ptr = (grant_q == GW'(NREQ - 1)) ? '0 : grant_q + GW'(1);

    // Round-robin scan starting at rr_q
    always_comb begin
        int idx;
        pick_found = 1'b0;
        pick_idx   = '0;
        idx        = 0;
        for (int i = 0; i < int'(NREQ); i++) begin
            idx = int'(rr_q) + i;
            if (idx >= int'(NREQ)) idx = idx - int'(NREQ);
            if (!pick_found && REQ_TVALID[idx]) begin
                pick_found = 1'b1;
                pick_idx   = GW'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (pick_found) state_d = ST_LOAD;
            ST_LOAD: if (in_hs && sel_last) state_d = ST_RUN;
            ST_RUN:  if (job_done) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Job bookkeeping: owner, round-robin pointer, kernel size, result countdown
    always_comb begin
        rr_d    = rr_q;
        grant_d = grant_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: if (pick_found) grant_d = pick_idx;
            ST_LOAD: begin
                if (in_hs && sel_user[0]) k_d = sel_user[K_BITS:1];
                if (in_hs && sel_last) cnt_d = calc_cnt(k_eff);
            end
            ST_RUN: begin
                if (out_hs) cnt_d = cnt_q - CNT_W'(1);
                if (job_done) rr_d = next_ptr;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_q    <= '0;
            grant_q <= '0;
            k_q     <= '0;
            cnt_q   <= '0;
        end else begin
            rr_q    <= rr_d;
            grant_q <= grant_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
        end
    end

    // Stream routing: zero-latency pass-through to and from the owner
    always_comb begin
        REQ_TREADY     = '0;
        RSP_TVALID     = '0;
        ENG_IN_TVALID  = 1'b0;
        ENG_OUT_TREADY = 1'b0;
        ENG_IN_TDATA   = sel_data;
        ENG_IN_TUSER   = sel_user;
        RSP_TDATA      = ENG_OUT_TDATA;
        case (state_q)
            ST_LOAD: begin
                ENG_IN_TVALID       = sel_valid;
                REQ_TREADY[grant_q] = ENG_IN_TREADY;
            end
            ST_RUN: begin
                RSP_TVALID[grant_q] = ENG_OUT_TVALID;
                ENG_OUT_TREADY      = sel_rsp_ready;
            end
            default: ;
        endcase
    end

    assign busy  = (state_q != ST_IDLE);
    assign grant = grant_q;

`ifdef ARB_STATS_EN
    logic [NREQ*16-1:0] stat_q, stat_d;

    // Saturating completed-job counters, one per requester
    always_comb begin
        stat_d = stat_q;
        if (job_done && (stat_q[int'(grant_q) * 16 +: 16] != 16'hFFFF))
            stat_d[int'(grant_q) * 16 +: 16] = stat_q[int'(grant_q) * 16 +: 16] + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) stat_q <= '0;
        else       stat_q <= stat_d;
    end

    assign job_done_cnt = stat_q;
`endif

endmodule

// File: tb/tb_conv_share_arb.sv
// Directed bench for conv_share_arb; the bench itself plays the engine on both sides.
module tb_conv_share_arb;

    localparam int INW  = 18;
    localparam int NREQ = 2;
    localparam int OUTW = 40;
    localparam int KB   = 3;
    localparam int TUW  = KB + 1;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NREQ*INW-1:0]  REQ_TDATA;
    logic [NREQ*TUW-1:0]  REQ_TUSER;
    logic [NREQ-1:0]      REQ_TVALID;
    logic [NREQ-1:0]      REQ_TLAST;
    logic [NREQ-1:0]      REQ_TREADY;
    logic [OUTW-1:0]      RSP_TDATA;
    logic [NREQ-1:0]      RSP_TVALID;
    logic [NREQ-1:0]      RSP_TREADY;
    logic [INW-1:0]       ENG_IN_TDATA;
    logic [TUW-1:0]       ENG_IN_TUSER;
    logic                 ENG_IN_TVALID;
    logic                 ENG_IN_TREADY;
    logic [OUTW-1:0]      ENG_OUT_TDATA;
    logic                 ENG_OUT_TVALID;
    logic                 ENG_OUT_TREADY;
    logic                 busy;
    logic [0:0]           grant;
`ifdef ARB_STATS_EN
    logic [NREQ*16-1:0]   job_done_cnt;
`endif

    conv_share_arb dut (
        .clk            (clk),
        .reset          (reset),
        .REQ_TDATA      (REQ_TDATA),
        .REQ_TUSER      (REQ_TUSER),
        .REQ_TVALID     (REQ_TVALID),
        .REQ_TLAST      (REQ_TLAST),
        .REQ_TREADY     (REQ_TREADY),
        .RSP_TDATA      (RSP_TDATA),
        .RSP_TVALID     (RSP_TVALID),
        .RSP_TREADY     (RSP_TREADY),
        .ENG_IN_TDATA   (ENG_IN_TDATA),
        .ENG_IN_TUSER   (ENG_IN_TUSER),
        .ENG_IN_TVALID  (ENG_IN_TVALID),
        .ENG_IN_TREADY  (ENG_IN_TREADY),
        .ENG_OUT_TDATA  (ENG_OUT_TDATA),
        .ENG_OUT_TVALID (ENG_OUT_TVALID),
        .ENG_OUT_TREADY (ENG_OUT_TREADY),
`ifdef ARB_STATS_EN
        .job_done_cnt   (job_done_cnt),
`endif
        .busy           (busy),
        .grant          (grant)
    );

    always #5 clk = ~clk;

    typedef struct {
        int n;          // requester expected to win
        int k;          // K carried on new_W beats
        int nw;         // beats with new_W=1
        int nx;         // beats with new_W=0
        bit oth;        // other requester also asserting valid
        bit bp;         // toggle RSP_TREADY of the owner
        bit st;         // hold ENG_IN_TREADY low 10 cycles mid-load
        int abort_at;   // pulse reset after this many results (-1: none)
        int exp_cnt;    // results the job must deliver
    } vec_t;

    vec_t tbl[11];
    int   n_cmp = 0;
    int   n_err = 0;
    int   done_cnt[NREQ];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [OUTW-1:0] res_val(input int job, input int i);
        return OUTW'((64'(job + 1) << 32) | 64'(i * 7 + 3));
    endfunction

    task automatic run_job(input vec_t v, input int job);
        int             o;
        int             total;
        int             got;
        bit             ok;
        bit             fin;
        logic [INW-1:0] d;
        logic [TUW-1:0] tu;
        o     = 1 - v.n;
        total = v.nw + v.nx;
        got   = 0;
        fin   = 1'b0;
        REQ_TVALID = '0;
        REQ_TLAST  = '0;
        REQ_TVALID[v.n] = 1'b1;
        REQ_TVALID[o]   = v.oth;
        REQ_TDATA[o*INW +: INW] = '1;
        REQ_TUSER[o*TUW +: TUW] = '1;
        REQ_TLAST[o]    = 1'b1;
        ENG_OUT_TVALID  = 1'b1;
        ENG_OUT_TDATA   = '1;
        RSP_TREADY      = '1;
        // Input load
        for (int b = 0; b < total; b++) begin
            d  = INW'(job * 1000 + b);
            tu = (b < v.nw) ? {KB'(v.k), 1'b1} : {3'd7, 1'b0};
            REQ_TDATA[v.n*INW +: INW] = d;
            REQ_TUSER[v.n*TUW +: TUW] = tu;
            REQ_TLAST[v.n]            = (b == total - 1);
            ok = 1'b0;
            for (int w = 0; w < 40 && !ok; w++) begin
                ENG_IN_TREADY = !(v.st && b == v.nw + 5 && w < 10);
                #1;
                chk("eng_out_held", {62'd0, ENG_OUT_TREADY, |RSP_TVALID}, 64'd0);
                if (busy) chk("grant", 64'(grant), 64'(v.n));
                if (REQ_TREADY[v.n] && ENG_IN_TVALID) begin
                    chk("in_data", 64'(ENG_IN_TDATA), 64'(d));
                    chk("in_user", 64'(ENG_IN_TUSER), 64'(tu));
                    chk("other_ready", 64'(REQ_TREADY[o]), 64'd0);
                    ok = 1'b1;
                end else if (busy) begin
                    chk("stall_ready", 64'(REQ_TREADY), 64'd0);
                    chk("stall_valid", 64'(ENG_IN_TVALID), 64'd1);
                end else begin
                    chk("idle_ready", 64'(REQ_TREADY), 64'd0);
                    chk("idle_valid", 64'(ENG_IN_TVALID), 64'd0);
                end
                step();
            end
            if (!ok) begin
                chk("load_timeout", 64'(b), 64'(total));
                break;
            end
        end
        REQ_TVALID[v.n] = 1'b0;
        REQ_TLAST       = '0;
        ENG_IN_TREADY   = 1'b1;
        // Result drain
        for (int w = 0; w < 600; w++) begin
            if (v.abort_at >= 0 && got == v.abort_at) begin
                reset = 1'b1;
                ENG_OUT_TVALID = 1'b1;
                step();
                reset = 1'b0;
                #1;
                chk("rst_busy", 64'(busy), 64'd0);
                chk("rst_grant", 64'(grant), 64'd0);
                chk("rst_req_ready", 64'(REQ_TREADY), 64'd0);
                chk("rst_rsp_valid", 64'(RSP_TVALID), 64'd0);
                chk("rst_eng_ready", 64'(ENG_OUT_TREADY), 64'd0);
                chk("rst_in_valid", 64'(ENG_IN_TVALID), 64'd0);
                for (int i = 0; i < NREQ; i++) done_cnt[i] = 0;
                REQ_TVALID = '0;
                ENG_OUT_TVALID = 1'b0;
                step();
                return;
            end
            ENG_OUT_TDATA  = res_val(job, got);
            ENG_OUT_TVALID = (w % 5 != 4);
            RSP_TREADY     = '1;
            if (v.bp) RSP_TREADY[v.n] = (w % 2 == 1);
            #1;
            if (!busy) begin
                fin = 1'b1;
                break;
            end
            chk("rsp_valid", 64'(RSP_TVALID), 64'(ENG_OUT_TVALID) << v.n);
            chk("eng_out_ready", 64'(ENG_OUT_TREADY), 64'(RSP_TREADY[v.n]));
            chk("run_req_ready", 64'(REQ_TREADY), 64'd0);
            chk("run_in_valid", 64'(ENG_IN_TVALID), 64'd0);
            if (RSP_TVALID[v.n] && RSP_TREADY[v.n]) begin
                chk("rsp_data", 64'(RSP_TDATA), 64'(res_val(job, got)));
                got++;
            end
            step();
        end
        chk("run_finished", 64'(fin), 64'd1);
        chk("result_count", 64'(got), 64'(v.exp_cnt));
        if (fin) done_cnt[v.n]++;
        ENG_OUT_TVALID = 1'b1;
        #1;
        chk("idle_eng_ready", 64'(ENG_OUT_TREADY), 64'd0);
        chk("idle_rsp_valid", 64'(RSP_TVALID), 64'd0);
        REQ_TVALID     = '0;
        ENG_OUT_TVALID = 1'b0;
        step();
    endtask

    initial begin
        //           n  k  nw  nx oth bp st  abort exp
        tbl[0]  = '{0, 3,  9, 72, 0, 0, 0, -1, 42};
        tbl[1]  = '{1, 5, 25, 72, 1, 0, 0, -1, 20};
        tbl[2]  = '{0, 5,  0, 72, 1, 0, 0, -1, 20};
        tbl[3]  = '{1, 2,  4, 72, 0, 1, 1, -1, 56};
        tbl[4]  = '{0, 1,  1, 72, 1, 0, 0, -1, 72};
        tbl[5]  = '{1, 3,  9, 72, 1, 0, 0, 25, 42};
        tbl[6]  = '{0, 3,  9, 72, 1, 0, 0, -1, 42};
        tbl[7]  = '{1, 4,  1,  0, 1, 0, 0, -1, 30};
        tbl[8]  = '{0, 2,  0, 72, 0, 1, 0, -1, 30};
        tbl[9]  = '{1, 5, 25, 72, 1, 1, 0, -1, 20};
        tbl[10] = '{0, 0,  0, 72, 1, 0, 0, -1, 20};

        for (int i = 0; i < NREQ; i++) done_cnt[i] = 0;
        reset          = 1'b1;
        REQ_TDATA      = '0;
        REQ_TUSER      = '0;
        REQ_TVALID     = '0;
        REQ_TLAST      = '0;
        RSP_TREADY     = '0;
        ENG_IN_TREADY  = 1'b1;
        ENG_OUT_TDATA  = '0;
        ENG_OUT_TVALID = 1'b0;
        step();
        step();
        reset = 1'b0;
        #1;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_grant", 64'(grant), 64'd0);
        chk("reset_req_ready", 64'(REQ_TREADY), 64'd0);
        chk("reset_rsp_valid", 64'(RSP_TVALID), 64'd0);
        chk("reset_in_valid", 64'(ENG_IN_TVALID), 64'd0);
        chk("reset_eng_ready", 64'(ENG_OUT_TREADY), 64'd0);
        step();
        chk("idle_stays_idle", 64'(busy), 64'd0);

        for (int j = 0; j < 11; j++) run_job(tbl[j], j);

`ifdef ARB_STATS_EN
        chk("job_done_cnt", 64'(job_done_cnt), 64'h0000_0002_0003);
        chk("job_done_model", 64'(job_done_cnt), {32'd0, 16'(done_cnt[1]), 16'(done_cnt[0])});
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
